ppd_sched: RTL and testbench

Input scheduler and enable controller for the polyphase decimation filter datapath (`mul_add`). It accepts one serial sample per valid strobe and commutates `gp_decimation_factor` samples into the parallel frame word the datapath consumes. It pulses the datapath's clock enable once per frame and flags which datapath outputs are valid once the transposed-form delay line is primed. It sits between the upstream sample source and `mul_add`; its enable output drives the datapath `i_ena`.

---
 rtl/ppd_pkg.sv | 21 ++
 rtl/ppd_commutator.sv | 56 +++++
 rtl/ppd_sched.sv | 80 ++++++++
 tb/tb_ppd_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppd_pkg.sv
// ppd_pkg: shared constants, helpers and state type for the polyphase decimator
package ppd_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    function automatic int DIV(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int c_col(input int l, input int d);
        return DIV(l, d);
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ppd_commutator.sv
// ppd_commutator: phase counter, lane staging and frame register for serial-to-parallel commutation
module ppd_commutator
    import ppd_pkg::*;
#(
    parameter int gp_idata_width       = 8,
    parameter int gp_decimation_factor = 4,
    parameter int gp_ccw               = 1
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_an,
    input  logic                                           i_ena,
    input  logic                                           i_clr,
    input  logic                                           i_valid,
    input  logic [gp_idata_width-1:0]                      i_data,
    output logic [gp_decimation_factor*gp_idata_width-1:0] o_data,
    output logic [clog2(gp_decimation_factor)-1:0]         o_phase,
    output logic                                           o_frame_done
);

    localparam int W  = gp_idata_width;
    localparam int D  = gp_decimation_factor;
    localparam int PW = clog2(D);

    logic [D*W-1:0] stage, stage_nxt;
    logic [PW-1:0]  lane;
    logic           accept, last;

    assign accept       = i_ena && i_valid && !i_clr;
    assign last         = o_phase == PW'(D - 1);
    assign o_frame_done = accept && last;
    assign lane         = (gp_ccw != 0) ? PW'(D - 1) - o_phase : o_phase;

    // staging word with the current sample dropped into its lane
    always_comb begin
        stage_nxt = stage;
        stage_nxt[lane*W +: W] = i_data;
    end

    // phase advance, lane capture and frame hand-off on the frame-completing sample
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            o_phase <= '0;
            stage   <= '0;
            o_data  <= '0;
        end else if (i_ena) begin
            if (i_clr) begin
                o_phase <= '0;
            end else if (i_valid) begin
                stage   <= stage_nxt;
                o_phase <= last ? '0 : o_phase + 1'b1;
                if (last) o_data <= stage_nxt;
            end
        end
    end

endmodule

// File: rtl/ppd_sched.sv
// ppd_sched: input scheduler and enable controller for the polyphase decimation datapath
module ppd_sched
    import ppd_pkg::*;
#(
    parameter int gp_idata_width       = 8,
    parameter int gp_decimation_factor = 4,
    parameter int gp_coeff_length      = 17,
    parameter int gp_ccw               = 1
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_an,
    input  logic                                           i_ena,
    input  logic                                           i_clr,
    input  logic                                           i_valid,
    input  logic [gp_idata_width-1:0]                      i_data,
    output logic [gp_decimation_factor*gp_idata_width-1:0] o_data,
    output logic                                           o_filt_ena,
    output logic                                           o_valid,
    output logic [clog2(gp_decimation_factor)-1:0]         o_phase,
    output logic                                           o_primed
);

    localparam int C_COL = c_col(gp_coeff_length, gp_decimation_factor);
    localparam int CW    = clog2(C_COL + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] wcnt;
    logic          pend, frame_done, warm_done;

    assign warm_done = wcnt == CW'(C_COL - 1);

    ppd_commutator #(
        .gp_idata_width      (gp_idata_width),
        .gp_decimation_factor(gp_decimation_factor),
        .gp_ccw              (gp_ccw)
    ) u_comm (
        .i_clk       (i_clk),
        .i_rst_an    (i_rst_an),
        .i_ena       (i_ena),
        .i_clr       (i_clr),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_phase     (o_phase),
        .o_frame_done(frame_done)
    );

    // state register, frozen while the global enable is low
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) state <= IDLE;
        else if (i_ena) state <= state_nxt;
    end

    // a frame completing with c_col-1 frames already behind it is the first valid one
    always_comb begin
        state_nxt = i_clr                                  ? IDLE :
                    (frame_done && warm_done)              ? RUN  :
                    (i_valid && state == IDLE)             ? FILL : state;
    end

    // warm-up frame count and the pending enable pulse; a pulse only retires on an enabled cycle
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            wcnt <= '0;
            pend <= 1'b0;
        end else if (i_ena) begin
            pend <= frame_done;
            if (i_clr) wcnt <= '0;
            else if (frame_done && !warm_done) wcnt <= wcnt + 1'b1;
        end
    end

    // enable pulse gated by the global enable so a held-off pulse fires exactly once
    always_comb begin
        o_primed   = state == RUN;
        o_filt_ena = pend && i_ena;
        o_valid    = pend && i_ena && state == RUN;
    end

endmodule

// File: tb/tb_ppd_sched.sv
// tb_ppd_sched: randomized and directed checks of ppd_sched against a frame-level reference model
module tb_ppd_sched;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int L     = 17;
    localparam int FW    = D * W;
    localparam int C_COL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_ena = 1'b0, i_clr = 1'b0, i_valid = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic [FW-1:0] data1, data0;
    logic          filt1, filt0, valid1, valid0, primed1, primed0;
    logic [1:0]    phase1, phase0;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]  cur[$];
    logic [FW-1:0] m_d1, m_d0;
    int            m_frames;
    bit            m_pend;

    logic [FW-1:0] ramp_w[10];
    int            pulses, vcount, g, n;
    bit            seen, prim_prev, v;

    always #5 clk = ~clk;

    ppd_sched #(.gp_idata_width(W), .gp_decimation_factor(D), .gp_coeff_length(L), .gp_ccw(1)) u_ccw (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(i_ena), .i_clr(i_clr), .i_valid(i_valid), .i_data(i_data),
        .o_data(data1), .o_filt_ena(filt1), .o_valid(valid1), .o_phase(phase1), .o_primed(primed1)
    );

    ppd_sched #(.gp_idata_width(W), .gp_decimation_factor(D), .gp_coeff_length(L), .gp_ccw(0)) u_cw (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(i_ena), .i_clr(i_clr), .i_valid(i_valid), .i_data(i_data),
        .o_data(data0), .o_filt_ena(filt0), .o_valid(valid0), .o_phase(phase0), .o_primed(primed0)
    );

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        m_d1 = '0;
        m_d0 = '0;
        m_frames = 0;
        m_pend = 0;
    endtask

    // frame-level reference: a frame is D accepted samples; frames numbered from 0 after clear,
    // frame f is valid when f >= C_COL-1, i.e. once C_COL frames have completed
    task automatic model_edge(input bit ena, input bit clr, input bit vld, input logic [W-1:0] d);
        if (!ena) return;
        m_pend = 0;
        if (clr) begin
            cur.delete();
            m_frames = 0;
            return;
        end
        if (!vld) return;
        cur.push_back(d);
        if (cur.size() == D) begin
            m_d1 = '0;
            m_d0 = '0;
            for (int p = 0; p < D; p++) begin
                m_d1 = m_d1 | (FW'(cur[p]) << ((D - 1 - p) * W));
                m_d0 = m_d0 | (FW'(cur[p]) << (p * W));
            end
            cur.delete();
            m_pend = 1;
            m_frames++;
        end
    endtask

    task automatic check();
        bit e_filt, e_primed;
        e_filt   = m_pend && i_ena;
        e_primed = m_frames >= C_COL;
        lit("data_ccw", data1, m_d1);
        lit("data_cw", data0, m_d0);
        lit("filt_ena_ccw", filt1, e_filt);
        lit("filt_ena_cw", filt0, e_filt);
        lit("valid_ccw", valid1, e_filt && e_primed);
        lit("valid_cw", valid0, e_filt && e_primed);
        lit("phase_ccw", phase1, cur.size());
        lit("phase_cw", phase0, cur.size());
        lit("primed_ccw", primed1, e_primed);
        lit("primed_cw", primed0, e_primed);
    endtask

    task automatic cycle(input bit ena, input bit clr, input bit vld, input logic [W-1:0] d);
        @(negedge clk);
        i_ena = ena;
        i_clr = clr;
        i_valid = vld;
        i_data = d;
        #1;
        check();
        model_edge(ena, clr, vld, d);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        lit("reset_data_ccw", data1, 0);
        lit("reset_data_cw", data0, 0);
        lit("reset_ctrl", {filt1, valid1, primed1, phase1, filt0, valid0, primed0, phase0}, 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) cycle(1, 0, 1, W'(i));
        cycle(1, 0, 0, 0);
        lit("first_frame_word", data1, 64'h01020304);
        lit("first_frame_pulse", filt1, 1);
        lit("first_frame_valid", valid1, 0);

        cycle(1, 1, 0, 0);
        pulses = 0;
        seen = 0;
        prim_prev = 0;
        for (int i = 1; i <= 41; i++) begin
            cycle(1, 0, i <= 40, W'(i));
            if (filt1) begin
                ramp_w[pulses] = data1;
                pulses++;
            end
            if (valid1 && !seen) begin
                seen = 1;
                lit("first_valid_pulse_no", pulses, 5);
                lit("first_valid_word_cw", data0, 64'h14131211);
                lit("first_valid_word_ccw", data1, 64'h11121314);
                lit("primed_at_first_valid", primed1, 1);
                lit("primed_before_first_valid", prim_prev, 0);
            end
            prim_prev = primed1;
        end
        lit("ramp_pulses", pulses, 10);
        lit("ramp_saw_valid", seen, 1);

        cycle(1, 1, 0, 0);
        n = 1;
        g = 0;
        for (int c = 0; c < 2000 && n <= 40; c++) begin
            v = $urandom_range(0, 9) < 3;
            cycle(1, 0, v, W'(n));
            if (v) n++;
            if (filt1 && g < 10) begin
                lit("gapped_frame_word", data1, ramp_w[g]);
                g++;
            end
        end
        repeat (2) begin
            cycle(1, 0, 0, 0);
            if (filt1 && g < 10) begin
                lit("gapped_frame_word", data1, ramp_w[g]);
                g++;
            end
        end
        lit("gapped_frames", g, 10);

        for (int i = 0; i < 3; i++) cycle(1, 0, 1, W'(50 + i));
        cycle(1, 1, 1, 53);
        cycle(1, 0, 0, 0);
        lit("clr_phase", phase1, 0);
        lit("clr_primed", primed1, 0);
        vcount = 0;
        pulses = 0;
        for (int i = 1; i <= 21; i++) begin
            cycle(1, 0, i <= 20, W'(i));
            if (valid1) vcount++;
            if (filt1) pulses++;
        end
        lit("post_clr_pulses", pulses, 5);
        lit("post_clr_valid_frames", vcount, 1);

        for (int i = 0; i < 4; i++) cycle(1, 0, 1, W'(i + 60));
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            lit("held_off_pulse", filt1, 0);
        end
        cycle(1, 0, 0, 0);
        lit("released_pulse", filt1, 1);
        cycle(1, 0, 0, 0);
        lit("pulse_not_doubled", filt1, 0);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, W'($urandom));

        cycle(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 1, W'(i + 90));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        lit("async_reset_data_ccw", data1, 0);
        lit("async_reset_data_cw", data0, 0);
        lit("async_reset_ctrl", {filt1, valid1, primed1, phase1, filt0, valid0, primed0, phase0}, 0);
        model_reset();
        i_ena = 1'b0;
        i_valid = 1'b0;
        i_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 1, 8'h77);
        lit("post_reset_phase0", phase1, 0);
        cycle(1, 0, 1, 8'h78);
        lit("post_reset_phase1", phase1, 1);
        for (int i = 0; i < 40; i++) cycle(1, 0, $urandom_range(0, 1) == 1, W'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
